imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
- Inverse of the immediate extender: packs a 32-bit signed immediate into the RV32I I/S/B/J field layout of an instruction word.
- Used by the instruction loader/assembler path that streams encoded words into instruction memory.
- Flags immediates that cannot be represented in the chosen format.
- Valid/ready streaming block: 2-entry output buffer and a byte-address counter that tags each emitted word.

Parameters:
ADDR_W, 32, width of the emitted byte address.
START_ADDR, 0, address tagged on the first word after reset/clear (must be a multiple of 4).
ERRCNT_W, 8, width of the saturating error counter.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
clr  input  1  synchronous clear: flush buffer, reload address, zero counter.
in_valid  input  1  request valid.
in_ready  output  1  block can accept a request this cycle.
in_base  input  32  instruction word with non-immediate fields (opcode, rd, rs1, rs2, funct).
in_imm_src  input  2  format select: 00 I, 01 S, 10 B, 11 J (same encoding as ImmSrc).
in_imm  input  32  signed immediate to encode.
out_valid  output  1  encoded word available.
out_ready  input  1  consumer accepts the word.
out_instr  output  32  encoded instruction.
out_addr  output  ADDR_W  byte address for out_instr.
out_err  output  1  immediate was not representable; the word is still emitted.
err_cnt  output  ERRCNT_W  saturating count of emitted words with out_err=1.

Behaviour:
- Reset (rst_n low, async):
  - buffer empty, so out_valid=0 and in_ready=1.
  - out_instr=0, out_err=0, out_addr=START_ADDR, err_cnt=0.
- Accept: in_valid & in_ready at a rising edge pushes one entry.
- Emit: out_valid & out_ready at a rising edge pops the head and advances out_addr by 4. out_addr wraps modulo 2^ADDR_W.
- Latency: a word accepted at edge N is presented at out_* after edge N when the buffer was empty. No combinational path from in_* to out_*.
- Buffer: 2 entries, in_ready = (count<2).
  - Registered entry fields: instr, err.
  - out_addr is a separate counter, not stored per entry.
  - Push and pop in the same cycle: count unchanged; order preserved.
  - When full, in_valid is ignored (in_ready=0). out_* stay stable while out_valid=1 and out_ready=0.
- Encoding: bits outside the format's immediate fields are copied from in_base. Immediate fields overwrite in_base.
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- Legality (err=1 if violated):
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - On error the word is still encoded from the truncated bits.
- Round-trip invariant: for a legal imm, sign-extending the encoded fields with the same ImmSrc returns in_imm exactly.
- err_cnt increments on pop of an entry with err=1 and saturates at all-ones.
- clr (synchronous, highest priority):
  - empties the buffer, discards any same-cycle push/pop.
  - out_addr=START_ADDR, err_cnt=0.
  - in_ready=1 on the next cycle.
- Reset mid-stream: all buffered words are lost; no partial output.

Test Plan:
- I-type, base=0x00000013, imm=-1 (0xFFFFFFFF) -> out_instr=0xFFF00013, out_err=0, out_addr=START_ADDR one cycle after accept.
- S-type, base=0x00002023, imm=0x7FF -> out_instr=0x7E002FA3; then imm=0x800 -> out_err=1, err_cnt=1 after pop.
- B-type, base=0x00000063, imm=-4 (0xFFFFFFFC) -> out_instr=0xFE000EE3; imm=3 -> out_err=1 (odd offset).
- J-type, base=0x0000006F, imm=0x000FFFFE -> out_instr=0x7FFFF06F, err=0; imm=0x00100000 -> err=1.
- Backpressure: out_ready=0, push 3 words -> in_ready=0 after 2 pushes, third held off. Then out_ready=1 for 3 cycles -> words in order at addresses 0, 4, 8, with one push and one pop per cycle at count=1.
- Random legal imm/ImmSrc for 10k cycles against an extender model -> round-trip equal. Then clr mid-stream -> out_valid=0, out_addr=START_ADDR, err_cnt=0 next cycle. Then rst_n low asynchronously -> outputs at reset values before the next edge.

Source files
------------

// File: rtl/imm_encoder.sv
// Packs a signed 32-bit immediate into the RV32I I/S/B/J field layout of a base word,
// buffering encoded words in a 2-entry valid/ready output stage tagged with a byte address.
module imm_encoder #(
   parameter int unsigned ADDR_W               = 32,
   parameter logic [ADDR_W-1:0] START_ADDR     = '0,
   parameter int unsigned ERRCNT_W             = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_base,
   input  logic [1:0]          in_imm_src,
   input  logic [31:0]         in_imm,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [31:0]         out_instr,
   output logic [ADDR_W-1:0]   out_addr,
   output logic                out_err,
   output logic [ERRCNT_W-1:0] err_cnt
);

   localparam int unsigned INSTR_W = 32;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic               err;
   } entry_t;

   localparam logic [1:0] SRC_I = 2'b00;
   localparam logic [1:0] SRC_S = 2'b01;
   localparam logic [1:0] SRC_B = 2'b10;
   localparam logic [1:0] SRC_J = 2'b11;

   entry_t              head_q, head_d;
   entry_t              tail_q, tail_d;
   logic                head_vld_q, head_vld_d;
   logic                tail_vld_q, tail_vld_d;
   logic                rdy_q, rdy_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ERRCNT_W-1:0] ecnt_q, ecnt_d;
   entry_t              enc;
   logic                push, pop;

   // Overlay the immediate fields on the base word and flag values that do not fit.
   always_comb begin
      enc.instr = in_base;
      enc.err   = 1'b0;
      unique case (in_imm_src)
         SRC_I: begin
            enc.instr[31:20] = in_imm[11:0];
            enc.err          = !((&in_imm[31:11]) || !(|in_imm[31:11]));
         end
         SRC_S: begin
            enc.instr[31:25] = in_imm[11:5];
            enc.instr[11:7]  = in_imm[4:0];
            enc.err          = !((&in_imm[31:11]) || !(|in_imm[31:11]));
         end
         SRC_B: begin
            enc.instr[31]    = in_imm[12];
            enc.instr[30:25] = in_imm[10:5];
            enc.instr[11:8]  = in_imm[4:1];
            enc.instr[7]     = in_imm[11];
            enc.err          = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
         end
         SRC_J: begin
            enc.instr[31]    = in_imm[20];
            enc.instr[30:21] = in_imm[10:1];
            enc.instr[20]    = in_imm[11];
            enc.instr[19:12] = in_imm[19:12];
            enc.err          = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
         end
         default: ;
      endcase
   end

   assign push = in_valid && rdy_q;
   assign pop  = head_vld_q && out_ready;

   // Head/tail buffer next state; clear overrides any same-cycle push or pop.
   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      head_vld_d = head_vld_q;
      tail_vld_d = tail_vld_q;
      addr_d     = addr_q;
      ecnt_d     = ecnt_q;

      if (pop) begin
         addr_d = addr_q + ADDR_W'(4);
         if (head_q.err && (ecnt_q != {ERRCNT_W{1'b1}}))
            ecnt_d = ecnt_q + ERRCNT_W'(1);
         if (tail_vld_q) begin
            head_d     = tail_q;
            tail_vld_d = push;
            if (push) tail_d = enc;
         end else begin
            head_vld_d = push;
            if (push) head_d = enc;
         end
      end else if (push) begin
         if (head_vld_q) begin
            tail_d     = enc;
            tail_vld_d = 1'b1;
         end else begin
            head_d     = enc;
            head_vld_d = 1'b1;
         end
      end

      if (clr) begin
         head_vld_d = 1'b0;
         tail_vld_d = 1'b0;
         addr_d     = START_ADDR;
         ecnt_d     = '0;
      end

      rdy_d = !tail_vld_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q     <= '0;
         tail_q     <= '0;
         head_vld_q <= 1'b0;
         tail_vld_q <= 1'b0;
         rdy_q      <= 1'b1;
         addr_q     <= START_ADDR;
         ecnt_q     <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         head_vld_q <= head_vld_d;
         tail_vld_q <= tail_vld_d;
         rdy_q      <= rdy_d;
         addr_q     <= addr_d;
         ecnt_q     <= ecnt_d;
      end
   end

   assign in_ready  = rdy_q;
   assign out_valid = head_vld_q;
   assign out_instr = head_q.instr;
   assign out_err   = head_q.err;
   assign out_addr  = addr_q;
   assign err_cnt   = ecnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Randomized bench for imm_encoder: a queue-based stream model with an immediate
// extender and range-based legality rules predicts every output each cycle.
module tb_imm_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_base;
   logic [1:0]  in_imm_src;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_addr;
   logic        out_err;
   logic [7:0]  err_cnt;

   imm_encoder dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_base(in_base), .in_imm_src(in_imm_src), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_addr(out_addr),
      .out_err(out_err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] base;
      logic [1:0]  src;
      logic [31:0] imm;
      bit          has_exp;
      logic [31:0] exp;
   } req_t;

   req_t        q[$];
   logic [31:0] m_addr;
   int          m_ecnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Bits of the word that carry the immediate for each format.
   function automatic logic [31:0] fmask(input logic [1:0] src);
      case (src)
         2'd0:    return 32'hFFF0_0000;
         2'd3:    return 32'hFFFF_F000;
         default: return 32'hFE00_0F80;
      endcase
   endfunction

   // Immediate extender: what the decoder would recover from the word.
   function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] src);
      logic signed [31:0] v;
      case (src)
         2'd0:    v = 32'($signed(w[31:20]));
         2'd1:    v = 32'($signed({w[31:25], w[11:7]}));
         2'd2:    v = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
         default: v = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      endcase
      return v;
   endfunction

   function automatic bit legal(input logic [31:0] imm, input logic [1:0] src);
      int v;
      v = int'(imm);
      case (src)
         2'd0, 2'd1: return (v >= -2048) && (v <= 2047);
         2'd2:       return (v >= -4096) && (v <= 4094) && (imm[0] == 1'b0);
         default:    return (v >= -1048576) && (v <= 1048574) && (imm[0] == 1'b0);
      endcase
   endfunction

   function automatic logic [31:0] rand_imm(input logic [1:0] src);
      int v;
      if ($urandom_range(0, 7) == 0) return $urandom;
      case (src)
         2'd0, 2'd1: v = int'($urandom_range(0, 4095)) - 2048;
         2'd2:       v = (int'($urandom_range(0, 4095)) - 2048) * 2;
         default:    v = (int'($urandom_range(0, 1048575)) - 524288) * 2;
      endcase
      return 32'(v);
   endfunction

   task automatic compare_outputs();
      bit lg;
      check("in_ready", 32'(in_ready), 32'(q.size() < 2));
      check("out_valid", 32'(out_valid), 32'(q.size() > 0));
      check("out_addr", out_addr, m_addr);
      check("err_cnt", 32'(err_cnt), 32'(m_ecnt));
      if (q.size() > 0) begin
         lg = legal(q[0].imm, q[0].src);
         check("out_err", 32'(out_err), 32'(!lg));
         check("base_bits", out_instr & ~fmask(q[0].src), q[0].base & ~fmask(q[0].src));
         if (lg) check("round_trip", extend(out_instr, q[0].src), q[0].imm);
         if (q[0].has_exp) check("instr", out_instr, q[0].exp);
      end
   endtask

   // One clock: check current outputs, drive inputs, advance the model, step past the edge.
   task automatic cycle(input bit iv, input logic [31:0] base, input logic [1:0] src,
                        input logic [31:0] imm, input bit ordy,
                        input bit he = 1'b0, input logic [31:0] exp = 32'h0);
      bit   push, pop;
      req_t r;
      compare_outputs();
      clr        = 1'b0;
      in_valid   = iv;
      in_base    = base;
      in_imm_src = src;
      in_imm     = imm;
      out_ready  = ordy;
      push = iv && (q.size() < 2);
      pop  = (q.size() > 0) && ordy;
      if (pop) begin
         if (!legal(q[0].imm, q[0].src) && m_ecnt < 255) m_ecnt++;
         void'(q.pop_front());
         m_addr += 32'd4;
      end
      if (push) begin
         r.base = base; r.src = src; r.imm = imm; r.has_exp = he; r.exp = exp;
         q.push_back(r);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      q.delete();
      m_addr = 32'h0;
      m_ecnt = 0;
   endtask

   initial begin
      logic [1:0] s;
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_base = '0; in_imm_src = '0; in_imm = '0;
      model_reset();
      #12;
      check("rst_instr", out_instr, 32'h0);
      compare_outputs();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed encodings with known words
      cycle(1, 32'h0000_0013, 2'd0, 32'hFFFF_FFFF, 1, 1, 32'hFFF0_0013);
      cycle(1, 32'h0000_2023, 2'd1, 32'h0000_07FF, 1, 1, 32'h7E00_2FA3);
      cycle(1, 32'h0000_2023, 2'd1, 32'h0000_0800, 1);
      cycle(1, 32'h0000_0063, 2'd2, 32'hFFFF_FFFC, 1, 1, 32'hFE00_0EE3);
      cycle(1, 32'h0000_0063, 2'd2, 32'h0000_0003, 1);
      cycle(1, 32'h0000_006F, 2'd3, 32'h000F_FFFE, 1, 1, 32'h7FFF_F06F);
      cycle(1, 32'h0000_006F, 2'd3, 32'h0010_0000, 1);
      cycle(0, 32'h0, 2'd0, 32'h0, 1);
      cycle(0, 32'h0, 2'd0, 32'h0, 1);
      check("err_cnt_directed", 32'(err_cnt), 32'd3);

      // Backpressure: third word held off until a slot frees
      cycle(0, 32'h0, 2'd0, 32'h0, 0);
      clr = 1'b1; @(posedge clk); #1; model_reset();
      cycle(1, 32'h0000_0013, 2'd0, 32'h0000_0001, 0, 1, 32'h0010_0013);
      cycle(1, 32'h0000_0013, 2'd0, 32'h0000_0002, 0, 1, 32'h0020_0013);
      cycle(1, 32'h0000_0013, 2'd0, 32'h0000_0003, 0, 1, 32'h0030_0013);
      check("full_ready", 32'(in_ready), 32'd0);
      cycle(1, 32'h0000_0013, 2'd0, 32'h0000_0003, 1, 1, 32'h0030_0013);
      cycle(1, 32'h0000_0013, 2'd0, 32'h0000_0003, 1, 1, 32'h0030_0013);
      cycle(0, 32'h0, 2'd0, 32'h0, 1);
      check("bp_addr", out_addr, 32'd12);
      cycle(0, 32'h0, 2'd0, 32'h0, 1);

      // Random stream
      for (int i = 0; i < 10000; i++) begin
         s = 2'($urandom_range(0, 3));
         cycle($urandom_range(0, 3) != 0, $urandom, s, rand_imm(s), $urandom_range(0, 3) != 0);
      end
      while (q.size() < 2) cycle(1, $urandom, 2'd0, 32'h0000_0800, 0);

      // Clear mid-stream, with a push and pop offered the same cycle
      compare_outputs();
      clr = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      model_reset();
      compare_outputs();
      check("clr_valid", 32'(out_valid), 32'd0);
      cycle(0, 32'h0, 2'd0, 32'h0, 1);

      // Asynchronous reset mid-stream
      cycle(1, 32'h0000_0013, 2'd0, 32'h0000_0800, 0);
      cycle(1, 32'h0000_0013, 2'd0, 32'h0000_0005, 0);
      compare_outputs();
      in_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_ready", 32'(in_ready), 32'd1);
      check("arst_instr", out_instr, 32'h0);
      check("arst_err", 32'(out_err), 32'd0);
      check("arst_addr", out_addr, 32'h0);
      check("arst_cnt", 32'(err_cnt), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      model_reset();
      @(posedge clk); #1;
      cycle(1, 32'h0000_0013, 2'd0, 32'h0000_0123, 1, 1, 32'h1230_0013);
      cycle(0, 32'h0, 2'd0, 32'h0, 1);
      compare_outputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
